// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: branch tags, ALU/compare encodings and the
// reservation-station entry layout with its CDB snoop helper.
package rv32i_types;

    localparam int ROB_TAG_MAX = 64;

    typedef logic [3:0]             branch_tag_t;
    typedef logic [ROB_TAG_MAX-1:0] rob_tag_t;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic [2:0] {
        cmp_beq  = 3'b000,
        cmp_bne  = 3'b001,
        cmp_blt  = 3'b100,
        cmp_bge  = 3'b101,
        cmp_bltu = 3'b110,
        cmp_bgeu = 3'b111
    } cmp_ops;

    typedef struct packed {
        logic        rdy;
        logic [31:0] val;
        rob_tag_t    tag;
    } rs_operand_t;

    typedef struct packed {
        logic        valid;
        logic [2:0]  op;
        logic [1:0]  rd_type;
        branch_tag_t br_tag;
        rob_tag_t    rob;
        rs_operand_t src1;
        rs_operand_t src2;
    } rs_entry_t;

    // Capture a broadcast value into an operand still waiting on that tag.
    function automatic rs_operand_t snoop(input rs_operand_t opnd, input logic cdb_valid,
                                          input rob_tag_t cdb_tag, input logic [31:0] cdb_value);
        rs_operand_t res;
        res = opnd;
        if (!opnd.rdy && cdb_valid && (opnd.tag == cdb_tag)) begin
            res.rdy = 1'b1;
            res.val = cdb_value;
        end else begin
            res = opnd;
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index priority encoder: reports whether any request is set and
// the index of the lowest one.
module rs_prio_enc #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan downward so the lowest set request is the last one written.
    always_comb begin
        found = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = req[i] ? IW'(i) : idx;
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands are
// captured (directly, by dispatch bypass or CDB wakeup), then issues one per cycle.
module alu_reservation_station
    import rv32i_types::*;
#(
    parameter int RS_DEPTH  = 8,
    parameter int ROB_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 dispatch_valid,
    output logic                 dispatch_ready,
    input  logic [2:0]           dispatch_op,
    input  logic [1:0]           dispatch_rd_type,
    input  branch_tag_t          dispatch_br_tag,
    input  logic [ROB_WIDTH-1:0] dispatch_rob,
    input  logic                 src1_rdy,
    input  logic                 src2_rdy,
    input  logic [31:0]          src1_val,
    input  logic [31:0]          src2_val,
    input  logic [ROB_WIDTH-1:0] src1_tag,
    input  logic [ROB_WIDTH-1:0] src2_tag,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_rob,
    input  logic [31:0]          cdb_value,
    input  logic                 alu_busy,
    output logic                 issue_out,
    output logic [2:0]           issue_op,
    output logic [1:0]           issue_rd_type,
    output branch_tag_t          issue_br_tag,
    output logic [ROB_WIDTH-1:0] issue_rob,
    output logic [31:0]          issue_a,
    output logic [31:0]          issue_b
);

    localparam int IW = $clog2(RS_DEPTH);

    rs_entry_t         entries_r   [RS_DEPTH];
    rs_entry_t         entries_nxt [RS_DEPTH];
    rs_entry_t         new_entry_s;
    rs_entry_t         issue_e_s;
    logic [RS_DEPTH-1:0] free_vec_s;
    logic [RS_DEPTH-1:0] elig_vec_s;
    logic              free_found_s;
    logic              elig_found_s;
    logic [IW-1:0]     free_idx_s;
    logic [IW-1:0]     sel_idx_s;
    logic              accept_s;
    logic              issue_s;
    rob_tag_t          cdb_tag_s;

    // Free and eligible request vectors come from registered state only.
    always_comb begin
        free_vec_s = '0;
        elig_vec_s = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            free_vec_s[i] = !entries_r[i].valid;
            elig_vec_s[i] = entries_r[i].valid && entries_r[i].src1.rdy && entries_r[i].src2.rdy;
        end
    end

    rs_prio_enc #(.N(RS_DEPTH), .IW(IW)) u_alloc_enc (
        .req   (free_vec_s),
        .found (free_found_s),
        .idx   (free_idx_s)
    );

    rs_prio_enc #(.N(RS_DEPTH), .IW(IW)) u_select_enc (
        .req   (elig_vec_s),
        .found (elig_found_s),
        .idx   (sel_idx_s)
    );

    assign dispatch_ready = free_found_s;
    assign accept_s       = dispatch_valid && free_found_s && !flush;
    assign issue_s        = elig_found_s && !alu_busy && !flush;
    assign cdb_tag_s      = rob_tag_t'(cdb_rob);

    // Incoming entry, with operands that the CDB resolves in the same cycle.
    always_comb begin
        new_entry_s.valid   = 1'b1;
        new_entry_s.op      = dispatch_op;
        new_entry_s.rd_type = dispatch_rd_type;
        new_entry_s.br_tag  = dispatch_br_tag;
        new_entry_s.rob     = rob_tag_t'(dispatch_rob);
        new_entry_s.src1    = snoop(rs_operand_t'{src1_rdy, src1_val, rob_tag_t'(src1_tag)},
                                    cdb_valid, cdb_tag_s, cdb_value);
        new_entry_s.src2    = snoop(rs_operand_t'{src2_rdy, src2_val, rob_tag_t'(src2_tag)},
                                    cdb_valid, cdb_tag_s, cdb_value);
    end

    // Per-entry next state: flush, allocate, retire on issue, or wake up.
    always_comb begin
        entries_nxt = entries_r;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (flush) begin
                entries_nxt[i].valid = 1'b0;
            end else if (accept_s && (free_idx_s == IW'(i))) begin
                entries_nxt[i] = new_entry_s;
            end else if (issue_s && (sel_idx_s == IW'(i))) begin
                entries_nxt[i].valid = 1'b0;
            end else begin
                entries_nxt[i].src1 = snoop(entries_r[i].src1, cdb_valid, cdb_tag_s, cdb_value);
                entries_nxt[i].src2 = snoop(entries_r[i].src2, cdb_valid, cdb_tag_s, cdb_value);
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else begin
            entries_r <= entries_nxt;
        end
    end

    // Issue fields are zero whenever nothing issues.
    always_comb begin
        issue_e_s = entries_r[sel_idx_s];
        issue_out = issue_s;
        if (issue_s) begin
            issue_op      = issue_e_s.op;
            issue_rd_type = issue_e_s.rd_type;
            issue_br_tag  = issue_e_s.br_tag;
            issue_rob     = issue_e_s.rob[ROB_WIDTH-1:0];
            issue_a       = issue_e_s.src1.val;
            issue_b       = issue_e_s.src2.val;
        end else begin
            issue_op      = 3'b000;
            issue_rd_type = 2'b00;
            issue_br_tag  = '0;
            issue_rob     = '0;
            issue_a       = 32'h0;
            issue_b       = 32'h0;
        end
    end

endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Holds dispatched integer ALU and set-less-than micro-ops until both operands are available. Snoops the CDB to capture operands from producers still in flight. Issues one ready op per cycle into `alu_unit` whenever the unit is not busy. Sits between the dispatch/rename stage and `alu_unit`.

## Interface
- `RS_DEPTH`, default 8: number of entries, power of two, at least 2.
- `ROB_WIDTH`, default 64: width of every ROB tag field.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: pipeline flush; invalidates all entries.
- `dispatch_valid` in 1: a new op is presented.
- `dispatch_ready` out 1: at least one free entry exists.
- `dispatch_op` in 3: ALU operation encoding.
- `dispatch_rd_type` in 2: `2'b11` arithmetic, `2'b10` compare.
- `dispatch_br_tag` in `branch_tag_t`: branch tag carried with the op.
- `dispatch_rob` in ROB_WIDTH: destination ROB tag.
- `src1_rdy`, `src2_rdy` in 1 each: operand value is already valid.
- `src1_val`, `src2_val` in 32 each: operand value, used when the matching `srcN_rdy` is set.
- `src1_tag`, `src2_tag` in ROB_WIDTH each: producer ROB tag, used when `srcN_rdy` is clear.
- `cdb_valid` in 1: a CDB broadcast is present this cycle.
- `cdb_rob` in ROB_WIDTH: tag of the broadcast.
- `cdb_value` in 32: value of the broadcast.
- `alu_busy` in 1: `busy` output of `alu_unit`.
- `issue_out` out 1: drives `alu_unit.issue_in`.
- `issue_op` out 3: operation of the issued op.
- `issue_rd_type` out 2: rd type of the issued op.
- `issue_br_tag` out `branch_tag_t`: branch tag of the issued op.
- `issue_rob` out ROB_WIDTH: destination ROB tag of the issued op.
- `issue_a` out 32: first operand.
- `issue_b` out 32: second operand.

## Operation
- Entry fields: `valid`, `op`, `rd_type`, `br_tag`, `rob`, and for each operand `rdy`, `val`, `tag`.
- **Allocation**
  - A dispatch is accepted when `dispatch_valid && dispatch_ready && !flush`.
  - The op is written to the lowest-index free entry.
- **Dispatch-cycle bypass**
  - Applies when an operand arrives with `srcN_rdy=0` and `cdb_valid && cdb_rob==srcN_tag` in the same cycle.
  - That operand is stored with `rdy=1` and `val=cdb_value`.
- **Wakeup**
  - Every valid entry compares `cdb_rob` against each unready operand tag.
  - On a match, that operand's `rdy` is set and `val=cdb_value`.
  - Both operands of one entry may wake on the same broadcast.
- **Select**
  - An entry is eligible when `valid` is set and both operands are ready.
  - The lowest-index eligible entry is chosen.
- **Issue**
  - `issue_out = any_eligible && !alu_busy && !flush`.
  - When `issue_out` is high, the issue fields carry the chosen entry. `issue_a` is operand 1 and `issue_b` is operand 2.
  - The issued entry's `valid` is cleared at the clock edge.
  - When `issue_out` is low, all issue fields are 0.
- **Flush**: all `valid` bits are cleared at the edge. In a flush cycle, dispatch is dropped and `issue_out=0`.
- **Reset**: all entries are invalid. After reset, `dispatch_ready=1` and `issue_out=0`, and all issue fields are 0.

## Timing
- Dispatch accepted at edge N: the entry is eligible from cycle N+1 at the earliest.
  - A dispatch with both operands ready, an empty RS and `alu_busy=0` gives `issue_out=1` in cycle N+1.
- CDB wakeup at edge N: the entry is eligible in cycle N+1. There is no same-cycle wakeup-to-issue path.
- `issue_out` is combinational from registered entry state and `alu_busy`. `alu_unit` registers it.
- `dispatch_ready` is computed from registered state only.
  - An entry freed by an issue in cycle N is not offered to dispatch until cycle N+1.
  - Consequence with all entries full: dispatch is stalled for that cycle even when an issue occurs in it.
- Dispatch and issue in the same cycle never target the same entry. The dispatch target is free; the issue target is valid.
- Wakeup of an entry and its issue in the same cycle cannot occur, because the entry is not yet eligible.

## Structure
- Shared package `rv32i_types` holds:
  - `rs_entry_t`, the entry struct above.
  - Existing `branch_tag_t` and the ALU operation enums. No new encodings are added.
- One sub-module, `rs_prio_enc`: parameterised lowest-index priority encoder (request vector to `found` plus index).
  - One instance for free-slot allocation.
  - One instance for issue select.

## Test plan
- **Reset then ready dispatch**: after reset, dispatch add with src1=5 and src2=7, both ready, `alu_busy=0` → next cycle `issue_out=1`, `issue_op=alu_add`, `issue_a=5`, `issue_b=7`, `issue_rob` equals the dispatched tag; the following cycle `issue_out=0`.
- **Wakeup**: dispatch with src1 waiting on tag 3; at cycle N, `cdb_valid`, `cdb_rob=3`, `cdb_value=0xDEAD` → `issue_out=1` in cycle N+1 with `issue_a=0xDEAD`.
- **Bypass at dispatch**: `src2_rdy=0`, `src2_tag=9` while the CDB broadcasts tag 9 with value 0x42 in the same cycle → the op issues the next cycle with `issue_b=0x42`.
- **Full and back-pressure**:
  - Fill `RS_DEPTH` ready entries with `alu_busy=1` → `dispatch_ready=0`, `issue_out=0`.
  - Release `alu_busy` → entry 0 issues first; `dispatch_ready=1` one cycle later.
- **Flush**: 4 entries valid, `flush=1` together with `dispatch_valid=1` → `issue_out=0` that cycle; next cycle the RS is empty and the flushed-cycle op is absent.
- **Priority**: entries 2 and 5 both eligible → entry 2 issues, then entry 5 in the next cycle.
